bcd_display_scan: RTL and testbench
===================================

# bcd_display_scan

Time-multiplexed seven-segment display driver that consumes packed BCD digits from the counter datapath and drives a common-segment, per-digit-anode display. It snapshots all digits once per frame to prevent tearing, scans one digit per slot with a one-cycle anode guard, decodes BCD to segments, and optionally blanks leading zeros. It sits between the BCD counters and the board display pins.

## Interface
- DIGITS, 4, number of BCD digits scanned (≥1)
- SCAN_DIV, 50000, clock cycles per digit slot (≥2)
- SEG_ACTIVE_LOW, 1, 1 = seg/dp pins are driven low to light a segment
- AN_ACTIVE_LOW, 1, 1 = an pins are driven low to enable a digit
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  scan enable; 0 = display dark and scan held
- bcd_in  input  4*DIGITS  packed digits, digit k = bcd_in[4k+3:4k], digit 0 = rightmost/least significant
- dp_in  input  DIGITS  decimal point request per digit
- blank_lz  input  1  leading-zero blanking enable (sampled live)
- seg  output  7  segments {g,f,e,d,c,b,a}, registered
- dp  output  1  decimal point, registered
- an  output  DIGITS  digit enables, one-hot active, registered
- frame_tick  output  1  one-cycle pulse, registered

## Operation
- State: pre_cnt (0..SCAN_DIV-1), dig_idx (0..DIGITS-1), snap_bcd, snap_dp.
- enable=1: pre_cnt increments each cycle; at SCAN_DIV-1 it wraps to 0 and dig_idx advances, wrapping DIGITS-1→0.
- Snapshot: snap_bcd<=bcd_in and snap_dp<=dp_in in every cycle where dig_idx==0 and pre_cnt==0. No other cycle updates the snapshot while enable=1.
- Output registers are computed from the pre-edge pre_cnt/dig_idx/snap values:
  - pre_cnt==0 (guard cycle): an all inactive, seg all off, dp off.
  - Otherwise: an activates bit dig_idx only; seg = decode(snap digit dig_idx); dp = snap_dp[dig_idx].
- Decode (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; codes 10–15 = 40 (dash). Invert if SEG_ACTIVE_LOW.
- Leading-zero blanking: with blank_lz=1, digit k≥1 is blanked when snap digits k..DIGITS-1 all equal 0. A blanked digit keeps an all inactive for its whole slot, and its dp is suppressed. Digit 0 is never blanked. Codes 10–15 count as nonzero.
- enable=0: pre_cnt and dig_idx are held at 0, an is all inactive, seg/dp are off, frame_tick is 0, and the snapshot loads every cycle. On re-enable, scanning starts at the digit 0 guard cycle.
- frame_tick=1 in the cycle after each snapshot load while enable=1.

## Timing
- Reset (rst_n low, asynchronous): pre_cnt=0, dig_idx=0, snap=0, an all inactive, seg off, dp off, frame_tick=0.
- With the default active-low polarity, the inactive/off reset values are an = all 1, seg=7'h7F, dp=1.
- Reset deassertion mid-frame discards the frame. The first post-reset cycle is the digit 0 guard cycle, and the snapshot loads in it.
- Slot length is SCAN_DIV cycles: 1 guard cycle, then SCAN_DIV-1 cycles with the digit lit. Frame length is DIGITS*SCAN_DIV cycles.
- Output latency is 1 cycle from the internal state. A bcd_in change is displayed starting in the first slot of the next frame; worst case is DIGITS*SCAN_DIV+1 cycles.
- enable falling: outputs go inactive at the next edge. enable rising: the first lit digit 0 appears 2 edges later.
- No combinational path exists from any input to any output.

## Test plan
All tests use DIGITS=4, SCAN_DIV=4, both polarities active-low.
- Reset: hold rst_n=0 with enable=1 -> an=4'hF, seg=7'h7F, dp=1, frame_tick=0; release -> frame_tick pulses 2 cycles later and then every 16 cycles.
- Scan/decode: bcd_in=16'h1234, blank_lz=0, dp_in=4'b0010 -> guard cycle an=4'hF; digit 0 slot an=4'b1110, seg=7'h19, dp=1; digit 1 slot an=4'b1101, seg=7'h30, dp=0; each lit for 3 cycles.
- Leading zero: bcd_in=16'h0050, blank_lz=1 -> digit 3 and digit 2 slots keep an=4'hF throughout; digit 1 shows seg=7'h12; digit 0 shows seg=7'h40. Repeat with blank_lz=0 -> digits 3 and 2 show seg=7'h40.
- Invalid code: bcd_in=16'h00C0, blank_lz=1 -> digit 1 shows seg=7'h3F (dash) and is not blanked.
- Anti-tear: bcd_in=16'h1111, change to 16'h2222 during the digit 1 slot -> digits 2 and 3 still show seg=7'h79; after the next frame_tick, all digits show seg=7'h24.
- enable/reset mid-frame: drop enable during the digit 2 slot -> an=4'hF at the next edge and stays there; raise enable -> guard cycle, then digit 0 lit with the current bcd_in. Asserting rst_n mid-slot gives an=4'hF immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: frame-snapshotted, time-multiplexed BCD seven-segment scanner with leading-zero blanking
module bcd_display_scan #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AN_ACTIVE_LOW}};

  logic [CW-1:0]       pre_cnt_q, pre_cnt_d;
  logic [IW-1:0]       dig_idx_q, dig_idx_d;
  logic [4*DIGITS-1:0] snap_bcd_q, snap_bcd_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                tick_q, tick_d;
  logic [DIGITS-1:0]   blank;
  logic                zrun, frame_start, wrap, lit;

  function automatic logic [6:0] dec(input logic [3:0] b);
    case (b)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  always_comb begin
    frame_start = pre_cnt_q == '0 && dig_idx_q == '0;
    wrap = pre_cnt_q == CW'(SCAN_DIV - 1);
    zrun = 1'b1;
    blank = '0;
    // Walk from the most significant digit down; blanking stops at the first nonzero digit.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zrun = zrun && snap_bcd_q[4*k +: 4] == 4'd0;
      blank[k] = blank_lz && zrun && k != 0;
    end
    lit = enable && pre_cnt_q != '0 && !blank[dig_idx_q];
    pre_cnt_d = !enable || wrap ? '0 : pre_cnt_q + 1'b1;
    dig_idx_d = !enable ? '0 : !wrap ? dig_idx_q : dig_idx_q == IW'(DIGITS - 1) ? '0 : dig_idx_q + 1'b1;
    snap_bcd_d = !enable || frame_start ? bcd_in : snap_bcd_q;
    snap_dp_d = !enable || frame_start ? dp_in : snap_dp_q;
    an_d = lit ? AN_OFF ^ (DIGITS'(1) << dig_idx_q) : AN_OFF;
    seg_d = lit ? dec(snap_bcd_q[{dig_idx_q, 2'b00} +: 4]) ^ SEG_OFF : SEG_OFF;
    dp_d = lit ? snap_dp_q[dig_idx_q] ^ SEG_ACTIVE_LOW : SEG_ACTIVE_LOW;
    tick_d = enable && frame_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q  <= '0;
      dig_idx_q  <= '0;
      snap_bcd_q <= '0;
      snap_dp_q  <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= SEG_ACTIVE_LOW;
      an_q       <= AN_OFF;
      tick_q     <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      dig_idx_q  <= dig_idx_d;
      snap_bcd_q <= snap_bcd_d;
      snap_dp_q  <= snap_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      tick_q     <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: randomized bench for bcd_display_scan against a frame-position arithmetic model
module tb_bcd_display_scan;
  localparam int DIGITS = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME = DIGITS * SCAN_DIV;
  localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [12:0] DARK = {1'b0, 4'hF, 7'h7F, 1'b1};

  logic clk = 1'b0;
  logic rst_n, enable, blank_lz;
  logic [15:0] bcd_in;
  logic [3:0] dp_in, an;
  logic [6:0] seg;
  logic dp, frame_tick;

  int n_tests = 0;
  int n_fail = 0;

  int m_t;
  logic [15:0] m_snap;
  logic [3:0] m_dp;
  logic [12:0] e_out;
  logic e_tick;

  bcd_display_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bcd_in(bcd_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Expected {blanked, an, seg, dp} for position t within a frame, from the snapshot taken at t==0.
  function automatic logic [12:0] model_out(int t, logic [15:0] s, logic [3:0] d, logic bz);
    int slot = (t / SCAN_DIV) % DIGITS;
    int ph = t % SCAN_DIV;
    logic [15:0] upper = s >> (4 * slot);
    logic bl = bz && slot > 0 && upper == 16'h0;
    logic lit = ph != 0 && !bl;
    logic [3:0] dv = upper[3:0];
    logic [3:0] onehot = 4'b0001 << slot;
    return {bl, lit ? ~onehot : 4'hF, lit ? ~SEG_TAB[dv] : 7'h7F, lit ? ~d[slot] : 1'b1};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0;
      m_snap <= '0;
      m_dp <= '0;
      e_out <= DARK;
      e_tick <= 1'b0;
    end else if (!enable) begin
      m_t <= 0;
      m_snap <= bcd_in;
      m_dp <= dp_in;
      e_out <= DARK;
      e_tick <= 1'b0;
    end else begin
      if (m_t == 0) begin
        m_snap <= bcd_in;
        m_dp <= dp_in;
      end
      e_tick <= m_t == 0;
      e_out <= model_out(m_t, m_snap, m_dp, blank_lz);
      m_t <= (m_t + 1) % FRAME;
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("an", 32'(an), 32'(e_out[11:8]));
    if (!e_out[12]) check("seg", 32'(seg), 32'(e_out[7:1]));
    check("dp", 32'(dp), 32'(e_out[0]));
    check("tick", 32'(frame_tick), 32'(e_tick));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_an(string tag, logic [3:0] target);
    for (int i = 0; i < 3 * FRAME && an !== target; i++) step();
    check(tag, 32'(an), 32'(target));
  endtask

  initial begin
    rst_n = 1'b1;
    enable = 1'b1;
    bcd_in = 16'h1234;
    dp_in = 4'b0010;
    blank_lz = 1'b0;
    #1 rst_n = 1'b0;
    run(3);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    run(40);
    bcd_in = 16'h0050;
    blank_lz = 1'b1;
    run(36);
    blank_lz = 1'b0;
    run(36);
    bcd_in = 16'h00C0;
    blank_lz = 1'b1;
    run(36);
    bcd_in = 16'h1111;
    blank_lz = 1'b0;
    run(20);
    wait_an("wait_dig1", 4'b1101);
    bcd_in = 16'h2222;
    run(40);
    wait_an("wait_dig2", 4'b1011);
    enable = 1'b0;
    run(6);
    bcd_in = 16'h0987;
    enable = 1'b1;
    run(20);
    wait_an("wait_dig0", 4'b1110);
    #2 rst_n = 1'b0;
    #1 check("async_an", 32'(an), 32'h F);
    check("async_seg", 32'(seg), 32'h7F);
    step();
    rst_n = 1'b1;
    run(20);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        bcd_in = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
        dp_in = 4'($urandom);
        blank_lz = 1'($urandom);
      end
      if ($urandom_range(0, 59) == 0) enable = !enable;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
